// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access target.
// Holds the FSM state encoding and the byte-framing constants.
package i2c_pkg;

  localparam int I2C_BYTE_BITS  = 8;
  localparam int I2C_DATA_BYTES = 2;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  function automatic logic last_bit(input logic [2:0] cnt);
    return cnt == 3'(I2C_BYTE_BITS - 1);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// SCL/SDA synchronizers, edge detection and START/STOP detection.
// In: clk, rst, scl_in, sda_in. Out: one-cycle scl_rise/scl_fall/start/stop and synced sda level.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle-bus level so no spurious edges follow reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  // SCL must be high on both sides of the SDA edge.
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;
  assign sda      = sda_s;

endmodule

// File: rtl/i2c_peripheral.sv
// I2C target: address match, 8-bit register pointer, two data bytes in/out.
// Ports: clk, rst, scl_in, sda_in, sda_oe, reg_addr, wr_data, wr_valid, rd_req, rd_data, busy.
module i2c_peripheral
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter logic       WRITE_DIR   = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [7:0]  reg_addr,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  output logic        rd_req,
  input  logic [15:0] rd_data,
  output logic        busy
);

  localparam logic LAST_BYTE = 1'(I2C_DATA_BYTES - 1);

  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;
  logic       sda;

  i2c_state_t  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  rx_byte;
  logic [15:0] tx_sr;
  logic [7:0]  hi_byte;
  logic        dir_wr;
  logic        ack_drv;
  logic        byte_idx;
  logic        rd_cap;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_mon (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop),
    .sda     (sda)
  );

  assign rx_byte = {shreg[6:0], sda};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_sr    <= '0;
      hi_byte  <= '0;
      dir_wr   <= 1'b0;
      ack_drv  <= 1'b0;
      byte_idx <= 1'b0;
      rd_cap   <= 1'b0;
      sda_oe   <= 1'b0;
      reg_addr <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      // rd_data is valid the clk after rd_req.
      rd_cap   <= rd_req;
      if (rd_cap) tx_sr <= rd_data;

      if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
      end else if (stop) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            busy   <= 1'b0;
            sda_oe <= 1'b0;
          end

          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit(bit_cnt)) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  dir_wr <= (rx_byte[0] == WRITE_DIR);
                  busy   <= 1'b1;
                  state  <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                sda_oe   <= 1'b0;
                ack_drv  <= 1'b0;
                bit_cnt  <= '0;
                byte_idx <= 1'b0;
                state    <= REG;
              end
            end
          end

          REG: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit(bit_cnt)) begin
                reg_addr <= rx_byte;
                if (!dir_wr) rd_req <= 1'b1;
                state <= REG_ACK;
              end
            end
          end

          REG_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                bit_cnt <= '0;
                if (dir_wr) begin
                  sda_oe <= 1'b0;
                  state  <= WR_BYTE;
                end else begin
                  // The ACK release edge also launches the first read bit.
                  sda_oe <= ~tx_sr[15];
                  tx_sr  <= {tx_sr[14:0], 1'b0};
                  state  <= RD_BYTE;
                end
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit(bit_cnt)) begin
                if (byte_idx != LAST_BYTE) hi_byte <= rx_byte;
                state <= WR_ACK;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                ack_drv <= 1'b0;
                bit_cnt <= '0;
                if (byte_idx == LAST_BYTE) begin
                  state <= WAIT_STOP;
                end else begin
                  byte_idx <= byte_idx + 1'b1;
                  state    <= WR_BYTE;
                end
              end
            end else if (scl_rise && ack_drv && byte_idx == LAST_BYTE) begin
              wr_data  <= {hi_byte, shreg};
              wr_valid <= 1'b1;
            end
          end

          RD_BYTE: begin
            if (scl_fall) begin
              sda_oe <= ~tx_sr[15];
              tx_sr  <= {tx_sr[14:0], 1'b0};
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit(bit_cnt)) state <= RD_ACK;
            end
          end

          RD_ACK: begin
            // Release after bit 8 so the controller can answer.
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end else if (scl_rise) begin
              if (sda || byte_idx == LAST_BYTE) begin
                state <= WAIT_STOP;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                state    <= RD_BYTE;
              end
            end
          end

          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_peripheral.sv
// Directed bench for i2c_peripheral: bit-banged controller, transaction model, cycle checker.
// Drives scl/sda as an open-drain bus and checks acks, read bytes and register-bus pulses.
module tb_i2c_peripheral;

  localparam int Q = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [7:0]  reg_addr;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        rd_req;
  logic [15:0] rd_data = 16'h0000;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] regs [256];
  logic [23:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [23:0] e_wr;
  logic [7:0]  e_rd;
  logic [15:0] last_wr = 16'h0000;
  logic        no_drive = 1'b0;
  logic        prev_scl = 1'b1;
  logic        prev_oe = 1'b0;
  int          rd_stage = 0;
  logic [7:0]  rd_addr = 8'h00;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_peripheral dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .reg_addr(reg_addr),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .rd_req  (rd_req),
    .rd_data (rd_data),
    .busy    (busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic addr_hit(input logic [7:0] ab);
    return ab[7:1] == 7'h48;
  endfunction

  // Cycle checker plus register-bus read responder.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_stage == 1) begin
        rd_data  = regs[rd_addr];
        rd_stage = 2;
      end else if (rd_stage == 2) begin
        rd_data  = 16'h0000;
        rd_stage = 0;
      end
      if (wr_valid) begin
        chk("wr_expected", 32'(exp_wr.size() > 0), 1);
        chk("wr_rd_excl", rd_req, 0);
        if (exp_wr.size() > 0) begin
          e_wr = exp_wr.pop_front();
          chk("wr_reg", reg_addr, e_wr[23:16]);
          chk("wr_data", wr_data, e_wr[15:0]);
        end
        last_wr = wr_data;
      end
      if (rd_req) begin
        chk("rd_expected", 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) begin
          e_rd = exp_rd.pop_front();
          chk("rd_reg", reg_addr, e_rd);
        end
        rd_addr  = reg_addr;
        rd_stage = 1;
      end
      if (no_drive) begin
        chk("nodrive_oe", sda_oe, 0);
        chk("nodrive_busy", busy, 0);
      end
      if (scl_in && prev_scl) chk("sda_hold_scl_high", sda_oe, prev_oe);
    end
    prev_scl = scl_in;
    prev_oe  = sda_oe;
  end

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic seen);
    sda_m = b;
    qw();
    scl_m = 1'b1;
    qw();
    seen = sda_in;
    qw();
    scl_m = 1'b0;
    qw();
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    qw();
    scl_m = 1'b1;
    qw();
    sda_m = 1'b0;
    qw();
    scl_m = 1'b0;
    qw();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    qw();
    scl_m = 1'b1;
    qw();
    sda_m = 1'b1;
    qw();
    qw();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(~ack, s);
  endtask

  task automatic wr_txn(input logic [7:0] ab, input logic [7:0] ra,
                        input logic [15:0] d);
    logic a;
    logic hit;
    hit = addr_hit(ab) && ab[0];
    if (hit) exp_wr.push_back({ra, d});
    start_cond();
    write_byte(ab, a);
    chk("addr_ack", a, hit);
    write_byte(ra, a);
    chk("reg_ack", a, hit);
    write_byte(d[15:8], a);
    chk("d0_ack", a, hit);
    write_byte(d[7:0], a);
    chk("d1_ack", a, hit);
    chk("busy_pre_stop", busy, hit);
    stop_cond();
    chk("busy_post_stop", busy, 0);
    chk("wr_seen", exp_wr.size(), 0);
  endtask

  initial begin
    logic       a;
    logic       s;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] ab;

    for (int i = 0; i < 256; i++) regs[i] = 16'h0000;
    regs[5] = 16'h1234;

    repeat (4) @(negedge clk);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_rd_req", rd_req, 0);
    rst = 1'b0;
    qw();

    // Plain write.
    wr_txn(8'h91, 8'h1A, 16'hBEEF);
    chk("t1_last_wr", last_wr, 16'hBEEF);

    // Read with ACK then NACK.
    exp_rd.push_back(8'h05);
    start_cond();
    write_byte(8'h90, a);
    chk("rd_addr_ack", a, 1);
    write_byte(8'h05, a);
    chk("rd_reg_ack", a, 1);
    read_byte(b1, 1'b1);
    read_byte(b2, 1'b0);
    chk("rd_busy_pre_stop", busy, 1);
    stop_cond();
    chk("rd_b1", b1, regs[5][15:8]);
    chk("rd_b2", b2, regs[5][7:0]);
    chk("rd_b1_lit", b1, 8'h12);
    chk("rd_b2_lit", b2, 8'h34);
    chk("rd_seen", exp_rd.size(), 0);
    chk("rd_reg_addr", reg_addr, 8'h05);
    chk("rd_busy_post", busy, 0);

    // Wrong address never touches the bus.
    no_drive = 1'b1;
    wr_txn(8'h93, 8'h1A, 16'h5555);
    no_drive = 1'b0;

    // STOP in the middle of the second data byte.
    start_cond();
    write_byte(8'h91, a);
    chk("ab_addr_ack", a, 1);
    write_byte(8'h33, a);
    chk("ab_reg_ack", a, 1);
    write_byte(8'hAA, a);
    chk("ab_d0_ack", a, 1);
    ab = 8'h55;
    for (int i = 7; i >= 4; i--) bit_xfer(ab[i], s);
    stop_cond();
    qw();
    chk("ab_sda_oe", sda_oe, 0);
    chk("ab_busy", busy, 0);
    chk("ab_wr_data_kept", wr_data, 16'hBEEF);

    // Repeated START after the register ACK.
    start_cond();
    write_byte(8'h91, a);
    chk("rs_addr_ack", a, 1);
    write_byte(8'h10, a);
    chk("rs_reg_ack", a, 1);
    exp_wr.push_back({8'h20, 16'h00FF});
    start_cond();
    write_byte(8'h91, a);
    chk("rs2_addr_ack", a, 1);
    write_byte(8'h20, a);
    chk("rs2_reg_ack", a, 1);
    write_byte(8'h00, a);
    chk("rs2_d0_ack", a, 1);
    write_byte(8'hFF, a);
    chk("rs2_d1_ack", a, 1);
    stop_cond();
    chk("rs_wr_seen", exp_wr.size(), 0);
    chk("rs_last_wr", last_wr, 16'h00FF);

    // Reset while the target holds the address ACK low.
    start_cond();
    ab = 8'h91;
    for (int i = 7; i >= 0; i--) bit_xfer(ab[i], s);
    sda_m = 1'b1;
    qw();
    chk("rr_ack_driving", sda_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_sda_oe", sda_oe, 0);
    chk("rr_busy", busy, 0);
    chk("rr_reg_addr", reg_addr, 0);
    chk("rr_wr_data", wr_data, 0);
    chk("rr_wr_valid", wr_valid, 0);
    chk("rr_rd_req", rd_req, 0);
    qw();
    scl_m = 1'b1;
    qw();
    scl_m = 1'b0;
    qw();
    stop_cond();
    wr_txn(8'h91, 8'h42, 16'hCAFE);
    chk("rr_last_wr", last_wr, 16'hCAFE);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
